// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Bus master for an EN/MFC handshake memory. Takes one read or
//               write request at a time, drives a registered address/data/RW
//               set, strobes mem_EN, waits for the synchronised completion
//               flag to rise and then fall, and reports completion with a
//               one-cycle done pulse.
//               Optional feature macro: MEM_TIMEOUT_EN adds a per-phase
//               handshake timeout and drives err.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_EN,
    output logic              mem_RW,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_MFC
);

    // Synchroniser depth never drops below two flops.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]        state_q,    state_d;
    logic [SYNC_N-1:0] sync_q,     sync_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic              mem_en_q,   mem_en_d;
    logic              mem_rw_q,   mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q,  mem_din_d;

    logic mfc_s;
    logic strobe_ack;   // completion seen after our own strobe has been raised
    logic strobe_to;    // STROBE phase ran out of time
    logic release_to;   // RELEASE phase ran out of time

    assign mfc_s = sync_q[SYNC_N-1];
    // Requiring mem_EN already high means a stale MFC cannot end STROBE
    // before the memory has seen a rising strobe edge.
    assign strobe_ack = mem_en_q & mfc_s;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Phase counter: cleared on every state change, counts while waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == S_STROBE || state_q == S_RELEASE)
            cnt_d = cnt_q + 1'b1;
    end

    // Phase counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign strobe_to  = (state_q == S_STROBE)  && !strobe_ack &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign release_to = (state_q == S_RELEASE) && mfc_s &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign strobe_to  = 1'b0;
    assign release_to = 1'b0;
`endif

    // State, synchroniser and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sync_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b1;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_en_q   <= mem_en_d;
            mem_rw_q   <= mem_rw_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    // Next-state decode of the handshake sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req) state_d = S_SETUP;
            S_SETUP:   state_d = S_STROBE;
            S_STROBE:  if (strobe_ack || strobe_to) state_d = S_RELEASE;
            S_RELEASE: if (!mfc_s || release_to)    state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values, all landing in registers.
    always_comb begin
        sync_d     = {sync_q[SYNC_N-2:0], mem_MFC};
        busy_d     = busy_q;
        done_d     = (state_d == S_DONE);
        err_d      = err_q;
        rdata_d    = rdata_q;
        mem_en_d   = 1'b0;
        mem_rw_d   = mem_rw_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    mem_rw_d   = ~we;
                    mem_addr_d = addr_in;
                    mem_din_d  = wdata;
                end
            end
            S_STROBE: begin
                if (strobe_ack) begin
                    if (mem_rw_q)
                        rdata_d = mem_dout;
                end else if (strobe_to) begin
                    err_d = 1'b1;
                end else begin
                    mem_en_d = 1'b1;
                end
            end
            S_RELEASE: begin
                if (release_to)
                    err_d = 1'b1;
            end
            S_DONE: begin
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign mem_EN   = mem_en_q;
    assign mem_RW   = mem_rw_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule
`default_nettype wire
